// File: rtl/pe_seq_ctrl.sv
// Sequencer for one MAC PE: clears the accumulator, feeds vec_len operand pairs, returns psum.
// Optional RUN-state stall watchdog enabled by defining PE_SEQ_CTRL_TIMEOUT_EN.
module pe_seq_ctrl #(
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 8,
   parameter int PE_LAT  = 1,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  vec_len,
   input  logic              ifmap_valid,
   input  logic [DATA_W-1:0] ifmap_data,
   output logic              ifmap_ready,
   input  logic              filt_valid,
   input  logic [DATA_W-1:0] filt_data,
   output logic              filt_ready,
   output logic              pe_rst,
   output logic              pe_en,
   output logic [DATA_W-1:0] pe_ifmap,
   output logic [DATA_W-1:0] pe_filter,
   input  logic [DATA_W-1:0] pe_psum,
   output logic              psum_valid,
   output logic [DATA_W-1:0] psum_data,
   input  logic              psum_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_WAIT, S_OUT} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PE_LAT);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  len_reg, len_next;
   logic [CNT_W-1:0]  mac_cnt_reg, mac_cnt_next;
   logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
   logic [DATA_W-1:0] ifmap_q_reg, ifmap_q_next;
   logic [DATA_W-1:0] filt_q_reg, filt_q_next;
   logic [DATA_W-1:0] psum_reg, psum_next;
   logic              fire;
   logic              abort;

   assign fire = (state_reg == S_RUN) && ifmap_valid && filt_valid;

`ifdef PE_SEQ_CTRL_TIMEOUT_EN
   localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

   logic [STALL_W-1:0] stall_cnt_reg;

   // Counts consecutive non-fire RUN cycles; abort lands on the TIMEOUT-th one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt_reg <= '0;
      else if (state_reg != S_RUN || fire)
         stall_cnt_reg <= '0;
      else
         stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
   end

   assign abort = (state_reg == S_RUN) && !fire && (stall_cnt_reg == STALL_LAST);
`else
   localparam int unused_timeout = TIMEOUT;
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         len_reg      <= '0;
         mac_cnt_reg  <= '0;
         wait_cnt_reg <= '0;
         ifmap_q_reg  <= '0;
         filt_q_reg   <= '0;
         psum_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         mac_cnt_reg  <= mac_cnt_next;
         wait_cnt_reg <= wait_cnt_next;
         ifmap_q_reg  <= ifmap_q_next;
         filt_q_reg   <= filt_q_next;
         psum_reg     <= psum_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      mac_cnt_next  = mac_cnt_reg;
      wait_cnt_next = wait_cnt_reg;
      psum_next     = psum_reg;
      // Zero operands on idle cycles so the PE accumulates nothing.
      ifmap_q_next  = fire ? ifmap_data : '0;
      filt_q_next   = fire ? filt_data  : '0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               len_next     = vec_len;
               mac_cnt_next = '0;
               if (vec_len == '0) begin
                  psum_next  = '0;
                  state_next = S_OUT;
               end else begin
                  state_next = S_CLR;
               end
            end
         end
         S_CLR: state_next = S_RUN;
         S_RUN: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (fire) begin
               mac_cnt_next = mac_cnt_reg + CNT_ONE;
               if (mac_cnt_next == len_reg) begin
                  wait_cnt_next = '0;
                  state_next    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Final WAIT cycle: the last product has reached the PE output.
            if (wait_cnt_reg == WAIT_LAST) begin
               psum_next  = pe_psum;
               state_next = S_OUT;
            end else begin
               wait_cnt_next = wait_cnt_reg + CNT_ONE;
            end
         end
         S_OUT: if (psum_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign ifmap_ready = fire;
   assign filt_ready  = fire;
   assign pe_rst      = !rst || (state_reg == S_CLR) || abort;
   assign pe_en       = (state_reg == S_RUN) || (state_reg == S_WAIT);
   assign pe_ifmap    = ifmap_q_reg;
   assign pe_filter   = filt_q_reg;
   assign psum_valid  = (state_reg == S_OUT);
   assign psum_data   = psum_reg;
   assign busy        = (state_reg != S_IDLE);
   assign done        = (state_reg == S_OUT) && psum_ready;
   assign err         = abort;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a behavioural PE and a psum scoreboard.
// Timeout scenario runs only when PE_SEQ_CTRL_TIMEOUT_EN is defined.
module tb_pe_seq_ctrl;

   localparam int PE_LAT = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  vec_len;
   logic        ifmap_valid, filt_valid;
   logic [15:0] ifmap_data, filt_data;
   logic        ifmap_ready, filt_ready;
   logic        pe_rst, pe_en;
   logic [15:0] pe_ifmap, pe_filter, pe_psum;
   logic        psum_valid, psum_ready;
   logic [15:0] psum_data;
   logic        busy, done, err;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] op_i[8];
   logic [15:0] op_f[8];
   logic [15:0] acc;

   pe_seq_ctrl #(.DATA_W(16), .CNT_W(8), .PE_LAT(PE_LAT), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
      .ifmap_valid(ifmap_valid), .ifmap_data(ifmap_data), .ifmap_ready(ifmap_ready),
      .filt_valid(filt_valid), .filt_data(filt_data), .filt_ready(filt_ready),
      .pe_rst(pe_rst), .pe_en(pe_en), .pe_ifmap(pe_ifmap), .pe_filter(pe_filter),
      .pe_psum(pe_psum), .psum_valid(psum_valid), .psum_data(psum_data),
      .psum_ready(psum_ready), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural PE: one register stage, output forced to 0 while disabled.
   always @(posedge clk) begin
      if (pe_rst)     acc <= '0;
      else if (pe_en) acc <= acc + pe_ifmap * pe_filter;
   end
   assign pe_psum = pe_en ? acc : 16'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Scoreboard: every result handshake pops one expected psum.
   always @(negedge clk) begin
      if (rst && psum_valid && psum_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_result", 32'(psum_data), 32'hFFFF_FFFF);
         end else begin
            chk("sb_psum", 32'(psum_data), 32'(exp_q.pop_front()));
            chk("sb_done", 32'(done), 32'd1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input int n);
      start = 1'b1;
      vec_len = 8'(n);
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   // Feeds n operand pairs; filt_valid drops for gap_len cycles before pair gap_at.
   task automatic feed(input int n, input int gap_at, input int gap_len);
      int k = 0;
      int gap = 0;
      int budget = 0;
      logic stalled, fired;
      while (k < n && budget < 100) begin
         stalled = (k == gap_at) && (gap < gap_len);
         ifmap_valid = 1'b1;
         ifmap_data  = op_i[k];
         filt_valid  = !stalled;
         filt_data   = op_f[k];
         @(negedge clk);
         if (stalled && k > 0) begin
            chk("stall_ifmap_ready", 32'(ifmap_ready), 32'd0);
            chk("stall_filt_ready", 32'(filt_ready), 32'd0);
         end
         if (stalled) gap++;
         fired = ifmap_ready && filt_ready;
         tick();
         if (fired) k++;
         budget++;
      end
      ifmap_valid = 1'b0;
      filt_valid  = 1'b0;
      chk("feed_count", 32'(k), 32'(n));
   endtask

   // Waits for the result after the last fire, optionally back-pressures, then handshakes.
   task automatic finish(input logic [15:0] expv, input int rdy_delay);
      int lat = 0;
      while (!psum_valid && lat < 50) begin
         tick();
         lat++;
      end
      chk("result_latency", 32'(lat), 32'(PE_LAT + 1));
      for (int d = 0; d < rdy_delay; d++) begin
         chk("hold_valid", 32'(psum_valid), 32'd1);
         chk("hold_data", 32'(psum_data), 32'(expv));
         chk("hold_no_done", 32'(done), 32'd0);
         tick();
      end
      psum_ready = 1'b1;
      #1;
      chk("done_on_handshake", 32'(done), 32'd1);
      tick();
      psum_ready = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(psum_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; vec_len = '0;
      ifmap_valid = 1'b0; filt_valid = 1'b0; ifmap_data = '0; filt_data = '0;
      psum_ready = 1'b0;
      #3;
      chk("rst_pe_rst", 32'(pe_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_psum_valid", 32'(psum_valid), 32'd0);
      chk("rst_pe_en", 32'(pe_en), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("post_rst_pe_rst", 32'(pe_rst), 32'd0);

      // 1: 2*5 + 3*6 + 4*7 = 56, no stalls
      op_i[0] = 2; op_i[1] = 3; op_i[2] = 4;
      op_f[0] = 5; op_f[1] = 6; op_f[2] = 7;
      exp_q.push_back(16'd56);
      start_op(3);
      chk("clr_pe_rst", 32'(pe_rst), 32'd1);
      chk("clr_pe_en", 32'(pe_en), 32'd0);
      feed(3, 99, 0);
      finish(16'd56, 0);

      // 2: filter stalls 4 cycles, consumer stalls 3 cycles
      exp_q.push_back(16'd56);
      start_op(3);
      feed(3, 1, 4);
      finish(16'd56, 3);

      // 3: 300*300 wraps to 24464
      op_i[0] = 300; op_f[0] = 300;
      exp_q.push_back(16'd24464);
      start_op(1);
      feed(1, 99, 0);
      finish(16'd24464, 0);

      // 4: vec_len=0 produces 0 in the cycle after start, no operand consumed
      exp_q.push_back(16'd0);
      ifmap_valid = 1'b1; filt_valid = 1'b1;
      start_op(0);
      chk("zero_len_valid", 32'(psum_valid), 32'd1);
      chk("zero_len_ifmap_ready", 32'(ifmap_ready), 32'd0);
      chk("zero_len_filt_ready", 32'(filt_ready), 32'd0);
      chk("zero_len_data", 32'(psum_data), 32'd0);
      ifmap_valid = 1'b0; filt_valid = 1'b0;
      psum_ready = 1'b1;
      #1;
      chk("zero_len_done", 32'(done), 32'd1);
      tick();
      psum_ready = 1'b0;

      // 5: reset mid-RUN after 2 of 4 fires, then a clean 1*1 + 1*1
      for (int i = 0; i < 4; i++) begin op_i[i] = 9; op_f[i] = 9; end
      start_op(4);
      feed(2, 99, 0);
      ifmap_valid = 1'b1; filt_valid = 1'b1;
      rst = 1'b0;
      #1;
      chk("midrst_pe_rst", 32'(pe_rst), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_pe_en", 32'(pe_en), 32'd0);
      chk("midrst_pe_ifmap", 32'(pe_ifmap), 32'd0);
      chk("midrst_ready", 32'(ifmap_ready), 32'd0);
      tick(); tick();
      ifmap_valid = 1'b0; filt_valid = 1'b0;
      rst = 1'b1;
      tick();
      op_i[0] = 1; op_i[1] = 1; op_f[0] = 1; op_f[1] = 1;
      exp_q.push_back(16'd2);
      start_op(2);
      feed(2, 99, 0);
      finish(16'd2, 0);

`ifdef PE_SEQ_CTRL_TIMEOUT_EN
      // 6: one pair of two, then silence; abort 8 cycles after the last fire
      begin
         int c = 1;
         logic saw_valid = 1'b0;
         logic saw_err = 1'b0;
         op_i[0] = 3; op_f[0] = 3;
         start_op(2);
         feed(1, 99, 0);
         while (c < 40) begin
            @(negedge clk);
            if (psum_valid) saw_valid = 1'b1;
            if (err) begin
               saw_err = 1'b1;
               chk("timeout_pe_rst", 32'(pe_rst), 32'd1);
               break;
            end
            tick();
            c++;
         end
         chk("timeout_err_seen", 32'(saw_err), 32'd1);
         chk("timeout_cycles", 32'(c), 32'd8);
         tick();
         chk("timeout_busy", 32'(busy), 32'd0);
         chk("timeout_err_pulse", 32'(err), 32'd0);
         chk("timeout_no_valid", 32'(saw_valid), 32'd0);
      end
`else
      // 6: without the watchdog RUN waits indefinitely, then completes
      op_i[0] = 7; op_f[0] = 9;
      exp_q.push_back(16'd63);
      start_op(1);
      repeat (20) tick();
      chk("nowd_busy", 32'(busy), 32'd1);
      chk("nowd_err", 32'(err), 32'd0);
      chk("nowd_valid", 32'(psum_valid), 32'd0);
      feed(1, 99, 0);
      finish(16'd63, 0);
`endif

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
